// File: rtl/rsa_mod_exp_decrypt_if.sv
// Request/response bundle for the modexp decrypt engine: operands in, plaintext and status out.
interface rsa_mod_exp_decrypt_if #(parameter int W = 32);
  logic         start;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [W-1:0] n;
  logic         busy;
  logic         done;
  logic [W-1:0] m;
  logic         err;

  modport master (output start, c, d, n, input busy, done, m, err);
  modport slave  (input start, c, d, n, output busy, done, m, err);
endinterface

// File: rtl/rsa_mod_exp_decrypt.sv
// Constant-time RSA decrypt m = c^d mod n: left-to-right square-and-multiply over all W exponent bits,
// with every product reduced by a 2W-cycle restoring shift-subtract reducer.
module rsa_mod_exp_decrypt #(
  parameter int W = 32
) (
  input logic                 clk,
  input logic                 reset,
  rsa_mod_exp_decrypt_if.slave bus
);

  localparam int CW = $clog2(2 * W);
  localparam int IW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * W - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(W - 1);

  typedef enum logic [2:0] {IDLE, PREP, SQ, SQR, MU, MUR, FIN} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    d_q, d_d;
  logic [W-1:0]    n_q, n_d;
  logic [2*W-1:0]  p_q, p_d;
  logic [W:0]      rem_q, rem_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    base_q, base_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    m_q, m_d;
  logic            err_q, err_d;

  logic [W:0]      rem_sh, rem_red;
  logic [2*W-1:0]  acc_w, base_w;
  logic [W-1:0]    acc_mul;
  logic            red_last;

  // rem < n on entry, so the shifted value is below 2n and one subtraction is enough.
  assign rem_sh   = {rem_q[W-1:0], p_q[2*W-1]};
  assign rem_red  = (rem_sh >= {1'b0, n_q}) ? (rem_sh - {1'b0, n_q}) : rem_sh;
  assign red_last = (cnt_q == CNT_LAST);
  assign acc_w    = {{W{1'b0}}, acc_q};
  assign base_w   = {{W{1'b0}}, base_q};
  assign acc_mul  = d_q[idx_q] ? rem_red[W-1:0] : acc_q;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    n_d     = n_q;
    p_d     = p_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    m_d     = m_q;
    err_d   = err_q;

    if (state_q == PREP || state_q == SQR || state_q == MUR) begin
      p_d   = p_q << 1;
      rem_d = rem_red;
      cnt_d = cnt_q + CW'(1);
      if (red_last) begin
        rem_d = '0;
        cnt_d = '0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          d_d   = bus.d;
          n_d   = bus.n;
          p_d   = {{W{1'b0}}, bus.c};
          rem_d = '0;
          cnt_d = '0;
          if (bus.n == '0) begin
            m_d     = '0;
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = PREP;
          end
        end
      end
      PREP: begin
        if (red_last) begin
          base_d  = rem_red[W-1:0];
          acc_d   = (n_q == W'(1)) ? '0 : W'(1);
          idx_d   = IDX_TOP;
          state_d = SQ;
        end
      end
      SQ: begin
        p_d     = acc_w * acc_w;
        state_d = SQR;
      end
      SQR: begin
        if (red_last) begin
          acc_d   = rem_red[W-1:0];
          state_d = MU;
        end
      end
      MU: begin
        p_d     = acc_w * base_w;
        state_d = MUR;
      end
      MUR: begin
        if (red_last) begin
          acc_d = acc_mul;
          if (idx_q == '0) begin
            m_d     = acc_mul;
            err_d   = 1'b0;
            state_d = FIN;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = SQ;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      d_q     <= '0;
      n_q     <= '0;
      p_q     <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      m_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      n_q     <= n_d;
      p_q     <= p_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy = (state_q != IDLE) && (state_q != FIN);
  assign bus.done = (state_q == FIN);
  assign bus.m    = m_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_rsa_mod_exp_decrypt.sv
// Directed and random bench for the modexp decrypt engine with an expected-result queue.
module tb_rsa_mod_exp_decrypt;

  localparam int W   = 32;
  localparam int LAT = 1 + 2 * W + W * (4 * W + 2);

  typedef struct {
    logic [W-1:0] m;
    logic         err;
    int           lat;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  rsa_mod_exp_decrypt_if #(.W(W)) bus ();

  rsa_mod_exp_decrypt #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_modexp(logic [W-1:0] c, logic [W-1:0] d, logic [W-1:0] n);
    logic [63:0] r, b, nn;
    if (n == '0) return '0;
    nn = {32'd0, n};
    r  = 64'd1 % nn;
    b  = {32'd0, c} % nn;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % nn;
      if (d[i]) r = (r * b) % nn;
    end
    return r[W-1:0];
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Drives one request and checks the completion against the queued expectation.
  // With hold_start the request line stays high and the operands churn while busy.
  task automatic run_op(string tag, logic [W-1:0] c, logic [W-1:0] d, logic [W-1:0] n,
                        int exp_lat, bit hold_start);
    exp_t e, got;
    int   cyc;
    int   extra_done;
    e.m   = ref_modexp(c, d, n);
    e.err = (n == '0);
    e.lat = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.c = c;
    bus.d = d;
    bus.n = n;
    @(negedge clk);
    cyc = 1;
    if (!hold_start) bus.start = 1'b0;
    if (n != '0) check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    while (bus.done !== 1'b1 && cyc < exp_lat + 50) begin
      @(negedge clk);
      cyc++;
      if (hold_start) begin
        bus.c = $urandom;
        bus.d = $urandom;
        bus.n = $urandom;
      end
    end
    bus.start = 1'b0;
    got = sb.pop_front();
    check({tag, "_done_seen"}, 64'(bus.done), 64'd1);
    check({tag, "_lat"}, 64'(cyc), 64'(got.lat));
    check({tag, "_m"}, 64'(bus.m), 64'(got.m));
    check({tag, "_err"}, 64'(bus.err), 64'(got.err));
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_m_held"}, 64'(bus.m), 64'(got.m));
    if (hold_start) begin
      extra_done = 0;
      for (int k = 0; k < 20; k++) begin
        if (bus.done === 1'b1) extra_done++;
        @(negedge clk);
      end
      check({tag, "_single_done"}, 64'(extra_done), 64'd0);
    end
  endtask

  initial begin
    int done_cnt;
    logic [W-1:0] rc, rd, rn;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.c     = '0;
    bus.d     = '0;
    bus.n     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_m", 64'(bus.m), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);

    run_op("textbook", 32'd2790, 32'd2753, 32'd3233, LAT, 1'b0);
    check("textbook_m_65", 64'(bus.m), 64'd65);
    run_op("c_gt_n", 32'd6023, 32'd2753, 32'd3233, LAT, 1'b0);
    run_op("c_zero", 32'd0, 32'd5, 32'd3233, LAT, 1'b0);
    run_op("d_zero", 32'd1234, 32'd0, 32'd3233, LAT, 1'b0);
    run_op("d_zero_n_one", 32'd1234, 32'd0, 32'd1, LAT, 1'b0);
    run_op("n_zero", 32'd2790, 32'd2753, 32'd0, 1, 1'b0);
    run_op("err_clear", 32'd2790, 32'd2753, 32'd3233, LAT, 1'b0);
    run_op("start_held", 32'd2790, 32'd2753, 32'd3233, LAT, 1'b1);

    // Abort an operation mid-flight with a synchronous reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.c = 32'd2790;
    bus.d = 32'd2753;
    bus.n = 32'd3233;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (1999) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_m", 64'(bus.m), 64'd0);
    check("abort_err", 64'(bus.err), 64'd0);
    done_cnt = 0;
    for (int k = 0; k < LAT + 20; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    run_op("max_n", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 1'b0);
    check("max_n_m", 64'(bus.m), 64'hFFFF_FFFE);
    for (int r = 0; r < 3; r++) begin
      rc = $urandom;
      rd = $urandom;
      rn = $urandom;
      if (rn == '0) rn = 32'd97;
      run_op("random", rc, rd, rn, LAT, 1'b0);
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
